// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: carries IF-stage BTB predictions down to MEM, resolves
// them against the actual branch outcome, drives redirect/flush and queues
// predictor update records to the BTB.
// Optional performance counters are enabled with `define BRANCH_PERF_CNT_EN.
module branch_resolve_ctrl #(
    parameter int unsigned UPD_DEPTH  = 4,
    parameter int unsigned TRK_STAGES = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        valid_if_i,
    input  logic [31:0] pc_if_i,
    input  logic        pred_taken_if_i,
    input  logic [31:0] pred_target_if_i,
    input  logic        branch_mem_i,
    input  logic        taken_mem_i,
    input  logic [31:0] target_mem_i,
    output logic [31:0] next_pc_o,
    output logic        flush_o,
    output logic        upd_valid_o,
    input  logic        upd_ready_i,
    output logic [31:0] upd_pc_o,
    output logic        upd_taken_o,
    output logic [31:0] upd_target_o,
    output logic        stall_req_o,
    output logic        overflow_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int unsigned PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } trk_rec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_rec_t;

    trk_rec_t         trk_q [TRK_STAGES];
    trk_rec_t         trk_d [TRK_STAGES];
    trk_rec_t         rec_mem;

    upd_rec_t         fifo_q [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             mispred_c;
    logic             push_c;
    logic             pop_c;
    logic             full_c;
    logic             wr_en_c;
    logic             drop_c;

    assign rec_mem = trk_q[TRK_STAGES-1];

    // Resolution of the MEM record against the actual outcome
    always_comb begin
        mispred_c = 1'b0;
        push_c    = 1'b0;
        if (!stall_i && rec_mem.valid) begin
            push_c = branch_mem_i;
            if (branch_mem_i) begin
                if (taken_mem_i != rec_mem.pred_taken) begin
                    mispred_c = 1'b1;
                end else if (taken_mem_i && (target_mem_i != rec_mem.pred_target)) begin
                    mispred_c = 1'b1;
                end
            end else if (rec_mem.pred_taken) begin
                mispred_c = 1'b1;
            end
        end
    end

    // Redirect: resolved outcome on mispredict, else follow the IF prediction
    always_comb begin
        next_pc_o = pc_if_i + 32'd4;
        flush_o   = mispred_c;
        if (mispred_c) begin
            next_pc_o = (branch_mem_i && taken_mem_i) ? target_mem_i : (rec_mem.pc + 32'd4);
        end else if (valid_if_i && pred_taken_if_i) begin
            next_pc_o = pred_target_if_i;
        end
    end

    // Prediction-record shift chain; a mispredict kills everything younger
    always_comb begin
        for (int unsigned i = 0; i < TRK_STAGES; i++) begin
            trk_d[i] = trk_q[i];
        end
        if (!stall_i) begin
            trk_d[0].valid       = valid_if_i && !mispred_c;
            trk_d[0].pc          = pc_if_i;
            trk_d[0].pred_taken  = pred_taken_if_i;
            trk_d[0].pred_target = pred_target_if_i;
            for (int unsigned i = 1; i < TRK_STAGES; i++) begin
                trk_d[i] = trk_q[i-1];
                if (mispred_c) begin
                    trk_d[i].valid = 1'b0;
                end
            end
        end
    end

    // Tracking record registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < TRK_STAGES; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < TRK_STAGES; i++) begin
                trk_q[i] <= trk_d[i];
            end
        end
    end

    // Update FIFO control; a push into a full FIFO only lands if a pop frees a slot
    always_comb begin
        full_c     = (count_q == CNT_W'(UPD_DEPTH));
        pop_c      = (count_q != '0) && upd_ready_i;
        wr_en_c    = push_c && (!full_c || pop_c);
        drop_c     = push_c && full_c && !pop_c;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop_c;
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Update FIFO state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Update FIFO storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < UPD_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            fifo_q[wr_ptr_q].pc     <= rec_mem.pc;
            fifo_q[wr_ptr_q].taken  <= taken_mem_i;
            fifo_q[wr_ptr_q].target <= target_mem_i;
        end
    end

    assign upd_valid_o  = (count_q != '0);
    assign upd_pc_o     = fifo_q[rd_ptr_q].pc;
    assign upd_taken_o  = fifo_q[rd_ptr_q].taken;
    assign upd_target_o = fifo_q[rd_ptr_q].target;
    assign stall_req_o  = full_c;
    assign overflow_o   = overflow_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Saturating resolved-branch and mispredict counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (push_c && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispred_c && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    // Per-cycle performance report once any branch has resolved
    always_ff @(posedge clk_i) begin
        if (rst_ni && (branch_cnt_q != '0)) begin
            $display("branch_perf: branches=%0d mispredicts=%0d mispredict_pct=%0d",
                     branch_cnt_q, mispred_cnt_q,
                     (64'(mispred_cnt_q) * 64'd100) / 64'(branch_cnt_q));
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: prediction tracking, resolution,
// stall hold, update FIFO backpressure/overflow, PC wrap and mid-run reset.
module tb_branch_resolve_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        valid_if_i;
    logic [31:0] pc_if_i;
    logic        pred_taken_if_i;
    logic [31:0] pred_target_if_i;
    logic        branch_mem_i;
    logic        taken_mem_i;
    logic [31:0] target_mem_i;
    logic [31:0] next_pc_o;
    logic        flush_o;
    logic        upd_valid_o;
    logic        upd_ready_i;
    logic [31:0] upd_pc_o;
    logic        upd_taken_o;
    logic [31:0] upd_target_o;
    logic        stall_req_o;
    logic        overflow_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    branch_resolve_ctrl #(
        .UPD_DEPTH (4),
        .TRK_STAGES(3)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .stall_i         (stall_i),
        .valid_if_i      (valid_if_i),
        .pc_if_i         (pc_if_i),
        .pred_taken_if_i (pred_taken_if_i),
        .pred_target_if_i(pred_target_if_i),
        .branch_mem_i    (branch_mem_i),
        .taken_mem_i     (taken_mem_i),
        .target_mem_i    (target_mem_i),
        .next_pc_o       (next_pc_o),
        .flush_o         (flush_o),
        .upd_valid_o     (upd_valid_o),
        .upd_ready_i     (upd_ready_i),
        .upd_pc_o        (upd_pc_o),
        .upd_taken_o     (upd_taken_o),
        .upd_target_o    (upd_target_o),
        .stall_req_o     (stall_req_o),
        .overflow_o      (overflow_o),
        .branch_cnt_o    (branch_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] tg);
        valid_if_i       = v;
        pc_if_i          = pc;
        pred_taken_if_i  = pt;
        pred_target_if_i = tg;
    endtask

    task automatic idle_if();
        set_if(1'b0, 32'h0000_1000, 1'b0, 32'h0);
    endtask

    task automatic set_mem(input logic b, input logic t, input logic [31:0] tg);
        branch_mem_i = b;
        taken_mem_i  = t;
        target_mem_i = tg;
    endtask

    task automatic check_upd(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        check_eq({tag, "_valid"},  32'(upd_valid_o), 32'd1);
        check_eq({tag, "_pc"},     upd_pc_o, pc);
        check_eq({tag, "_taken"},  32'(upd_taken_o), 32'(tk));
        check_eq({tag, "_target"}, upd_target_o, tg);
    endtask

    logic [31:0] exp_branch_cnt;
    logic [31:0] exp_mispred_cnt;

    initial begin
`ifdef BRANCH_PERF_CNT_EN
        exp_branch_cnt  = 32'd9;
        exp_mispred_cnt = 32'd4;
`else
        exp_branch_cnt  = 32'd0;
        exp_mispred_cnt = 32'd0;
`endif
        rst_ni      = 1'b0;
        stall_i     = 1'b0;
        upd_ready_i = 1'b1;
        idle_if();
        set_mem(1'b0, 1'b0, 32'h0);

        // Reset state
        settle();
        check_eq("rst_next_pc",   next_pc_o, 32'h0000_1004);
        check_eq("rst_flush",     32'(flush_o), 32'd0);
        check_eq("rst_upd_valid", 32'(upd_valid_o), 32'd0);
        check_eq("rst_upd_pc",    upd_pc_o, 32'd0);
        check_eq("rst_upd_tgt",   upd_target_o, 32'd0);
        check_eq("rst_stall_req", 32'(stall_req_o), 32'd0);
        check_eq("rst_overflow",  32'(overflow_o), 32'd0);
        check_eq("rst_br_cnt",    branch_cnt_o, 32'd0);
        check_eq("rst_mp_cnt",    mispred_cnt_o, 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Correct taken prediction
        set_if(1'b1, 32'h100, 1'b1, 32'h200);
        settle();
        check_eq("s1_follow_pred", next_pc_o, 32'h200);
        step();
        idle_if();
        step();
        step();
        set_mem(1'b1, 1'b1, 32'h200);
        settle();
        check_eq("s1_flush", 32'(flush_o), 32'd0);
        check_eq("s1_next_pc", next_pc_o, 32'h0000_1004);
        step();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_upd("s1_upd", 32'h100, 1'b1, 32'h200);
        step();
        settle();
        check_eq("s1_popped", 32'(upd_valid_o), 32'd0);

        // Direction mispredict with younger instructions behind it
        set_if(1'b1, 32'h104, 1'b0, 32'h0);
        step();
        set_if(1'b1, 32'h108, 1'b0, 32'h0);
        step();
        set_if(1'b1, 32'h10C, 1'b0, 32'h0);
        step();
        set_if(1'b1, 32'h110, 1'b0, 32'h0);
        set_mem(1'b1, 1'b1, 32'h40);
        settle();
        check_eq("s2_flush", 32'(flush_o), 32'd1);
        check_eq("s2_next_pc", next_pc_o, 32'h40);
        step();
        idle_if();
        set_mem(1'b1, 1'b1, 32'h999);
        settle();
        check_upd("s2_upd", 32'h104, 1'b1, 32'h40);
        check_eq("s2_killed0_flush", 32'(flush_o), 32'd0);
        for (int k = 1; k < 3; k++) begin
            step();
            settle();
            check_eq($sformatf("s2_killed%0d_flush", k), 32'(flush_o), 32'd0);
            check_eq($sformatf("s2_killed%0d_nopush", k), 32'(upd_valid_o), 32'd0);
        end
        step();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("s2_killed_nopush", 32'(upd_valid_o), 32'd0);

        // False hit on a non-branch
        set_if(1'b1, 32'h108, 1'b1, 32'h300);
        settle();
        check_eq("s3_follow_pred", next_pc_o, 32'h300);
        step();
        idle_if();
        step();
        step();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("s3_flush", 32'(flush_o), 32'd1);
        check_eq("s3_next_pc", next_pc_o, 32'h10C);
        step();
        settle();
        check_eq("s3_nopush", 32'(upd_valid_o), 32'd0);

        // Mispredict held by stall until the first unstalled cycle
        set_if(1'b1, 32'h120, 1'b0, 32'h0);
        step();
        idle_if();
        step();
        step();
        stall_i = 1'b1;
        set_mem(1'b1, 1'b1, 32'h80);
        settle();
        check_eq("s4_stall0_flush", 32'(flush_o), 32'd0);
        check_eq("s4_stall0_next_pc", next_pc_o, 32'h0000_1004);
        step();
        settle();
        check_eq("s4_stall1_flush", 32'(flush_o), 32'd0);
        check_eq("s4_stall1_nopush", 32'(upd_valid_o), 32'd0);
        step();
        stall_i = 1'b0;
        settle();
        check_eq("s4_release_flush", 32'(flush_o), 32'd1);
        check_eq("s4_release_next_pc", next_pc_o, 32'h80);
        step();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_upd("s4_upd", 32'h120, 1'b1, 32'h80);
        step();

        // FIFO backpressure and overflow
        upd_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) set_if(1'b1, 32'h200 + 32'(4 * c), 1'b0, 32'h0);
            else       idle_if();
            if (c >= 3) set_mem(1'b1, 1'b0, 32'hA00 + 32'(c - 3));
            else        set_mem(1'b0, 1'b0, 32'h0);
            settle();
            if (c == 7) begin
                check_eq("s5_full_stall_req", 32'(stall_req_o), 32'd1);
                check_eq("s5_full_no_ovf", 32'(overflow_o), 32'd0);
            end
            step();
        end
        idle_if();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("s5_overflow", 32'(overflow_o), 32'd1);
        check_eq("s5_still_full", 32'(stall_req_o), 32'd1);
        check_upd("s5_hold", 32'h200, 1'b0, 32'hA00);
        upd_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_upd($sformatf("s5_drain%0d", k), 32'h200 + 32'(4 * k), 1'b0, 32'hA00 + 32'(k));
            step();
        end
        settle();
        check_eq("s5_empty", 32'(upd_valid_o), 32'd0);
        check_eq("s5_no_stall_req", 32'(stall_req_o), 32'd0);
        check_eq("s5_ovf_sticky", 32'(overflow_o), 32'd1);

        // PC+4 wrap on both redirect paths
        set_if(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        settle();
        check_eq("s6_seq_wrap", next_pc_o, 32'h0);
        set_if(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h400);
        settle();
        check_eq("s6_follow_pred", next_pc_o, 32'h400);
        step();
        idle_if();
        step();
        step();
        set_mem(1'b1, 1'b0, 32'h0);
        settle();
        check_eq("s6_flush", 32'(flush_o), 32'd1);
        check_eq("s6_wrap_next_pc", next_pc_o, 32'h0);
        step();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_upd("s6_upd", 32'hFFFF_FFFC, 1'b0, 32'h0);
        check_eq("s6_branch_cnt", branch_cnt_o, exp_branch_cnt);
        check_eq("s6_mispred_cnt", mispred_cnt_o, exp_mispred_cnt);
        step();

        // Reset mid-flight discards tracked records and queued updates
        upd_ready_i = 1'b0;
        set_if(1'b1, 32'h300, 1'b0, 32'h0);
        step();
        set_if(1'b1, 32'h304, 1'b1, 32'h900);
        step();
        set_if(1'b1, 32'h308, 1'b1, 32'h904);
        step();
        idle_if();
        set_mem(1'b1, 1'b0, 32'h304);
        step();
        set_mem(1'b1, 1'b1, 32'h900);
        step();
        set_mem(1'b0, 1'b0, 32'h0);
        settle();
        check_upd("s7_prereset", 32'h300, 1'b0, 32'h304);
        rst_ni = 1'b0;
        settle();
        check_eq("s7_rst_upd_valid", 32'(upd_valid_o), 32'd0);
        check_eq("s7_rst_upd_pc", upd_pc_o, 32'd0);
        check_eq("s7_rst_upd_target", upd_target_o, 32'd0);
        check_eq("s7_rst_overflow", 32'(overflow_o), 32'd0);
        check_eq("s7_rst_flush", 32'(flush_o), 32'd0);
        check_eq("s7_rst_br_cnt", branch_cnt_o, 32'd0);
        check_eq("s7_rst_mp_cnt", mispred_cnt_o, 32'd0);
        step();
        rst_ni = 1'b1;
        settle();
        check_eq("s7_no_stale_flush", 32'(flush_o), 32'd0);
        step();
        settle();
        check_eq("s7_no_stale_push", 32'(upd_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
